// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared types, constants and hex decode table for the 7-segment scanner
//
// Purpose : scan FSM state type, digit count and the 0-F segment table used by
//           seg7_hex_decode. Segment vectors are {a,b,c,d,e,f,g}, 1 = lit.
// Ports   : none (package)
package seg7_pkg;

  localparam int N_DIGITS = 4;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_t;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h7E;
      4'h1:    seg = 7'h30;
      4'h2:    seg = 7'h6D;
      4'h3:    seg = 7'h79;
      4'h4:    seg = 7'h33;
      4'h5:    seg = 7'h5B;
      4'h6:    seg = 7'h5F;
      4'h7:    seg = 7'h70;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h7B;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h1F;
      4'hC:    seg = 7'h4E;
      4'hD:    seg = 7'h3D;
      4'hE:    seg = 7'h4F;
      default: seg = 7'h47;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// rtl/seg7_scan_ctrl_if.sv - MCU write/status bus of the 7-segment scan controller
//
// Purpose : groups the register-write strobe and data plus the status returned
//           to the MCU.
// Signals : wr_en      1  one-cycle write strobe
//           wr_hex     16 nibble k -> digit k (digit 0 rightmost)
//           wr_dp      4  decimal point per digit, 1 = lit
//           wr_blank   4  1 = digit fully dark
//           pending    1  shadow holds data not yet on the display
//           frame_done 1  one-cycle pulse at the end of digit 3's slot
// Modports: master (MCU side), slave (controller side)
interface seg7_scan_ctrl_if;
  import seg7_pkg::*;

  logic                  wr_en;
  logic [4*N_DIGITS-1:0] wr_hex;
  logic [N_DIGITS-1:0]   wr_dp;
  logic [N_DIGITS-1:0]   wr_blank;
  logic                  pending;
  logic                  frame_done;

  modport master (
    output wr_en, wr_hex, wr_dp, wr_blank,
    input  pending, frame_done
  );

  modport slave (
    input  wr_en, wr_hex, wr_dp, wr_blank,
    output pending, frame_done
  );

endinterface

// File: rtl/seg7_hex_decode.sv
// rtl/seg7_hex_decode.sv - one-digit hex to abcdefgh decoder with dp, blanking and polarity
//
// Purpose : combinational segment pattern for the digit currently being shown.
// Ports   : nibble  in  4  hex value
//           dp      in  1  decimal point, 1 = lit
//           on      in  1  0 forces every segment inactive
//           seg     out 8  {a,b,c,d,e,f,g,h}, polarity per SEG_ACT_LOW
module seg7_hex_decode
  import seg7_pkg::*;
#(
  parameter bit SEG_ACT_LOW = 1'b1
) (
  input  logic [3:0] nibble,
  input  logic       dp,
  input  logic       on,
  output logic [7:0] seg
);

  logic [7:0] seg_lit;

  always_comb begin
    seg_lit = 8'h00;
    if (on) begin
      seg_lit = {hex_to_seg(nibble), dp};
    end
    seg = SEG_ACT_LOW ? ~seg_lit : seg_lit;
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - 4-digit multiplexed 7-segment scan controller
//
// Purpose : scans four digits, one slot of P = CLK_HZ/DIGIT_HZ cycles each. The first
//           BLANK_CYCLES of every slot keep all digits dark so the previous digit's
//           segments never ghost onto the next one. MCU writes land in a shadow bank
//           and are copied to the active bank only at the end of a frame.
// Ports   : clk       in   1  system clock
//           reset_n   in   1  asynchronous active-low reset
//           bus       if      seg7_scan_ctrl_if.slave (write bus, pending, frame_done)
//           abcdefgh  out  8  segments, bit7 = a ... bit1 = g, bit0 = dp
//           digit     out  4  digit enables, digit[k] selects digit k
// Params  : CLK_HZ, DIGIT_HZ, BLANK_CYCLES (1 .. P-1), SEG_ACT_LOW, DIG_ACT_LOW
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int DIGIT_HZ     = 1000,
  parameter int BLANK_CYCLES = 500,
  parameter bit SEG_ACT_LOW  = 1'b1,
  parameter bit DIG_ACT_LOW  = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  seg7_scan_ctrl_if.slave        bus,
  output logic [7:0]             abcdefgh,
  output logic [N_DIGITS-1:0]    digit
);

  localparam int P  = CLK_HZ / DIGIT_HZ;
  localparam int CW = (P > 1) ? $clog2(P) : 1;

  localparam logic [CW-1:0]       CNT_MAX  = CW'(P - 1);
  localparam logic [CW-1:0]       BLANK_C  = CW'(BLANK_CYCLES);
  localparam logic [7:0]          SEG_OFF  = SEG_ACT_LOW ? 8'hFF : 8'h00;
  localparam logic [N_DIGITS-1:0] DIG_OFF  = DIG_ACT_LOW ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};

  logic [CW-1:0]         cnt;
  logic [CW-1:0]         cnt_nxt;
  logic [1:0]            idx;
  state_t                state;
  logic                  wrap;
  logic                  commit;

  logic [4*N_DIGITS-1:0] shadow_hex;
  logic [N_DIGITS-1:0]   shadow_dp;
  logic [N_DIGITS-1:0]   shadow_blank;
  logic [4*N_DIGITS-1:0] active_hex;
  logic [N_DIGITS-1:0]   active_dp;
  logic [N_DIGITS-1:0]   active_blank;
  logic                  pending_q;

  logic                  dig_on;
  logic [N_DIGITS-1:0]   dig_sel;
  logic [7:0]            seg_nxt;

  assign wrap    = (cnt == CNT_MAX);
  assign cnt_nxt = wrap ? '0 : cnt + CW'(1);
  // Last cycle of digit 3's slot; the banks swap on the edge that ends it.
  assign commit  = wrap && (idx == 2'd3);

  assign bus.frame_done = commit;
  assign bus.pending    = pending_q;

  // Slot counter, digit index and BLANK/SHOW state. The state tracks the
  // current cnt, so the wrap always re-enters BLANK before idx moves on.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      idx   <= 2'd0;
      state <= BLANK;
    end else begin
      cnt <= cnt_nxt;
      if (wrap) begin
        idx <= idx + 2'd1;
      end
      case (state)
        BLANK:   if (cnt_nxt >= BLANK_C) state <= SHOW;
        SHOW:    if (wrap)               state <= BLANK;
        default:                         state <= BLANK;
      endcase
    end
  end

  // Shadow/active banks. A write landing on the commit edge goes straight to
  // the active bank so it is not held back for a whole extra frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_hex   <= '0;
      shadow_dp    <= '0;
      shadow_blank <= {N_DIGITS{1'b1}};
      active_hex   <= '0;
      active_dp    <= '0;
      active_blank <= {N_DIGITS{1'b1}};
      pending_q    <= 1'b0;
    end else begin
      if (bus.wr_en) begin
        shadow_hex   <= bus.wr_hex;
        shadow_dp    <= bus.wr_dp;
        shadow_blank <= bus.wr_blank;
      end
      if (commit) begin
        pending_q <= 1'b0;
        if (bus.wr_en) begin
          active_hex   <= bus.wr_hex;
          active_dp    <= bus.wr_dp;
          active_blank <= bus.wr_blank;
        end else if (pending_q) begin
          active_hex   <= shadow_hex;
          active_dp    <= shadow_dp;
          active_blank <= shadow_blank;
        end
      end else if (bus.wr_en) begin
        pending_q <= 1'b1;
      end
    end
  end

  assign dig_on  = (state == SHOW) && !active_blank[idx];
  assign dig_sel = N_DIGITS'(1) << idx;

  seg7_hex_decode #(
    .SEG_ACT_LOW (SEG_ACT_LOW)
  ) u_decode (
    .nibble (active_hex[4*idx +: 4]),
    .dp     (active_dp[idx]),
    .on     (dig_on),
    .seg    (seg_nxt)
  );

  // Pin registers: one cycle behind state/idx, so pins change only on clk.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      abcdefgh <= SEG_OFF;
      digit    <= DIG_OFF;
    end else begin
      abcdefgh <= seg_nxt;
      if (dig_on) begin
        digit <= DIG_ACT_LOW ? ~dig_sel : dig_sel;
      end else begin
        digit <= DIG_OFF;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb/tb_seg7_scan_ctrl.sv - directed self-checking bench for seg7_scan_ctrl
module tb_seg7_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] abcdefgh;
  logic [3:0] digit;
  int         n_checks = 0;
  int         n_fail = 0;
  logic [3:0] prev_dig = 4'hF;

  always #5 clk = ~clk;

  seg7_scan_ctrl_if bus ();

  seg7_scan_ctrl #(
    .CLK_HZ       (1000),
    .DIGIT_HZ     (100),
    .BLANK_CYCLES (2),
    .SEG_ACT_LOW  (1'b1),
    .DIG_ACT_LOW  (1'b1)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .abcdefgh (abcdefgh),
    .digit    (digit)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [15:0] h, input logic [3:0] dp, input logic [3:0] bl);
    bus.wr_hex   = h;
    bus.wr_dp    = dp;
    bus.wr_blank = bl;
    bus.wr_en    = 1'b1;
    step(1);
    bus.wr_en    = 1'b0;
  endtask

  task automatic wait_fd(input string tag);
    int n;
    n = 0;
    step(1);
    while (bus.frame_done !== 1'b1 && n < 100) begin
      step(1);
      n++;
    end
    chk(tag, 16'(bus.frame_done), 16'h1);
  endtask

  task automatic pins(input string tag, input logic [3:0] d, input logic [7:0] s);
    chk({tag, " digit"}, 16'(digit), 16'(d));
    chk({tag, " seg"}, 16'(abcdefgh), 16'(s));
  endtask

  // Scan invariants: at most one digit on, and never a direct hop between digits.
  always @(negedge clk) begin
    if (reset_n !== 1'b1) begin
      prev_dig = 4'hF;
    end else begin
      n_checks++;
      assert ($onehot0(~digit)) else begin
        n_fail++;
        $error("FAIL onehot digit observed=%0h expected=at most one low bit", digit);
      end
      n_checks++;
      assert (!(digit !== 4'hF && prev_dig !== 4'hF && digit !== prev_dig)) else begin
        n_fail++;
        $error("FAIL ghost digit observed=%0h expected=F between %0h and it", digit, prev_dig);
      end
      prev_dig = digit;
    end
  end

  initial begin
    bus.wr_en    = 1'b0;
    bus.wr_hex   = 16'h0;
    bus.wr_dp    = 4'h0;
    bus.wr_blank = 4'h0;

    // reset state
    step(3);
    pins("reset", 4'hF, 8'hFF);
    chk("reset pending", 16'(bus.pending), 16'h0);
    chk("reset frame_done", 16'(bus.frame_done), 16'h0);
    reset_n = 1'b1;

    // idle: dark display, frame_done every 40 cycles starting 39 cycles in
    step(38);
    chk("first fd early", 16'(bus.frame_done), 16'h0);
    step(1);
    chk("first fd", 16'(bus.frame_done), 16'h1);
    for (int i = 1; i <= 40; i++) begin
      step(1);
      chk("idle fd period", 16'(bus.frame_done), 16'(i == 40));
      chk("idle digit", 16'(digit), 16'hF);
    end

    // 1234 appears on the frame after the write
    step(5);
    wr(16'h1234, 4'h0, 4'h0);
    chk("pending after wr", 16'(bus.pending), 16'h1);
    wait_fd("fd 1234");
    chk("pending at fd", 16'(bus.pending), 16'h1);
    step(1);
    chk("pending cleared", 16'(bus.pending), 16'h0);
    step(1);  pins("k2 dark", 4'hF, 8'hFF);
    step(2);  pins("d0 first", 4'hE, 8'h99);
    step(7);  pins("d0 last", 4'hE, 8'h99);
    step(1);  pins("d1 gap", 4'hF, 8'hFF);
    step(2);  pins("d1 '3'", 4'hD, 8'h0D);
    step(20); pins("d3 '1'", 4'h7, 8'h9F);
    step(7);  pins("d3 last", 4'h7, 8'h9F);
    step(1);  pins("d3 end", 4'hF, 8'hFF);

    // ABCD written mid-frame: rest of frame stays 1234, next frame ABCD
    wait_fd("fd mid");
    step(15);
    wr(16'hABCD, 4'h0, 4'h0);
    chk("pending mid", 16'(bus.pending), 16'h1);
    step(8);  pins("old d2", 4'hB, 8'h25);
    step(10); pins("old d3", 4'h7, 8'h9F);
    wait_fd("fd abcd");
    step(4);  pins("abcd d0", 4'hE, 8'h85);
    step(10); pins("abcd d1", 4'hD, 8'h63);
    step(10); pins("abcd d2", 4'hB, 8'hC1);
    step(10); pins("abcd d3", 4'h7, 8'h11);
    chk("pending abcd", 16'(bus.pending), 16'h0);

    // write coincident with frame_done bypasses straight to the display
    wait_fd("fd bypass");
    wr(16'h00EF, 4'h0, 4'h0);
    chk("bypass pending", 16'(bus.pending), 16'h0);
    step(3);  pins("00ef d0", 4'hE, 8'h71);
    step(10); pins("00ef d1", 4'hD, 8'h61);
    step(10); pins("00ef d2", 4'hB, 8'h03);
    step(10); pins("00ef d3", 4'h7, 8'h03);
    chk("bypass pending later", 16'(bus.pending), 16'h0);

    // blank digit 3, dp on digit 0
    wr(16'h5678, 4'b0001, 4'b1000);
    wait_fd("fd blank");
    step(4);  pins("dp d0", 4'hE, 8'h00);
    step(10); pins("nodp d1", 4'hD, 8'h1F);
    step(20);
    for (int i = 0; i < 8; i++) begin
      chk("d3 blanked", 16'(digit), 16'hF);
      step(1);
    end

    // asynchronous reset in SHOW, then restart from digit 0
    wait_fd("fd reset");
    step(6);
    pins("pre reset", 4'hE, 8'h00);
    reset_n = 1'b0;
    #1;
    pins("async reset", 4'hF, 8'hFF);
    step(2);
    reset_n = 1'b1;
    chk("post reset pending", 16'(bus.pending), 16'h0);
    step(1);  pins("rel k1", 4'hF, 8'hFF);
    step(2);  pins("rel k3", 4'hF, 8'hFF);
    step(35);
    chk("rel fd early", 16'(bus.frame_done), 16'h0);
    step(1);
    chk("rel fd", 16'(bus.frame_done), 16'h1);
    wr(16'h9000, 4'h0, 4'h0);
    step(3);  pins("rel d0", 4'hE, 8'h03);
    step(30); pins("rel d3", 4'h7, 8'h09);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
